// File: rtl/uart_bit_timer.sv
// uart_bit_timer
//   Bit/frame timing engine shared by the UART TX and RX paths. Once a frame
//   is accepted it produces a mid-bit sample strobe and an end-of-bit shift
//   strobe at a runtime baud divisor. It also counts bits over a runtime frame
//   length and flags the final bit. Back-to-back frames are supported by
//   re-asserting start during the packet_done cycle.
//
// Ports
//   clk            system clock
//   rstn           asynchronous active-low reset
//   start          frame request, sampled on rising clk
//   abort          terminate the current frame immediately
//   baud_div       clocks per bit, latched when start is accepted
//   frame_bits     bits per frame, latched when start is accepted
//   busy           frame in progress
//   half_bit_flag  1-cycle strobe at bit centre (rounded down for odd divisors)
//   full_bit_flag  1-cycle strobe on the last cycle of each bit
//   bit_index      index of the current bit, 0 = start bit
//   packet_done    1-cycle strobe coincident with full_bit_flag of the last bit
//   cfg_err        1-cycle strobe: start rejected because of a bad config

module uart_bit_timer #(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned MAX_BITS  = 15,
    parameter int unsigned BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [BIT_WIDTH-1:0] frame_bits,
    output logic                 busy,
    output logic                 half_bit_flag,
    output logic                 full_bit_flag,
    output logic [BIT_WIDTH-1:0] bit_index,
    output logic                 packet_done,
    output logic                 cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [DIV_WIDTH-1:0] baud_count, baud_count_next;
    logic [DIV_WIDTH-1:0] div_l, div_l_next;
    logic [BIT_WIDTH-1:0] bit_count, bit_count_next;
    logic [BIT_WIDTH-1:0] len_l, len_l_next;
    logic                 cfg_err_q, cfg_err_next;

    logic cfg_valid;
    logic running;
    logic at_half;
    logic at_full;
    logic last_bit;

    assign cfg_valid = (baud_div >= DIV_WIDTH'(2))
                    && (frame_bits != '0)
                    && (frame_bits <= BIT_WIDTH'(MAX_BITS));

    // Strobes are suppressed in an abort cycle so a terminated frame never
    // reports a bit edge or completion.
    assign running  = (state == RUN);
    assign at_half  = running && !abort && (baud_count == (div_l >> 1));
    assign at_full  = running && !abort && (baud_count == (div_l - DIV_WIDTH'(1)));
    assign last_bit = (bit_count == (len_l - BIT_WIDTH'(1)));

    assign busy          = running;
    assign half_bit_flag = at_half;
    assign full_bit_flag = at_full;
    assign packet_done   = at_full && last_bit;
    assign bit_index     = bit_count;
    assign cfg_err       = cfg_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            baud_count <= '0;
            bit_count  <= '0;
            div_l      <= '0;
            len_l      <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state      <= state_next;
            baud_count <= baud_count_next;
            bit_count  <= bit_count_next;
            div_l      <= div_l_next;
            len_l      <= len_l_next;
            cfg_err_q  <= cfg_err_next;
        end
    end

    always_comb begin
        state_next      = state;
        baud_count_next = baud_count;
        bit_count_next  = bit_count;
        div_l_next      = div_l;
        len_l_next      = len_l;
        cfg_err_next    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (cfg_valid) begin
                        state_next      = RUN;
                        div_l_next      = baud_div;
                        len_l_next      = frame_bits;
                        baud_count_next = '0;
                        bit_count_next  = '0;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    state_next      = IDLE;
                    baud_count_next = '0;
                    bit_count_next  = '0;
                end else if (at_full) begin
                    baud_count_next = '0;
                    if (last_bit) begin
                        bit_count_next = '0;
                        // A start coinciding with the final bit edge chains the
                        // next frame without an idle cycle.
                        if (start && cfg_valid) begin
                            div_l_next = baud_div;
                            len_l_next = frame_bits;
                        end else begin
                            state_next   = IDLE;
                            cfg_err_next = start;
                        end
                    end else begin
                        bit_count_next = bit_count + BIT_WIDTH'(1);
                    end
                end else begin
                    baud_count_next = baud_count + DIV_WIDTH'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
